// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux: multiplexed BCD display scanner with bank select, leading-zero blanking and blink
// Ports: clk, rst_n (async active-low); digits_in packed BCD per bank; bank_sel bank switch;
// en scan enable; blank_lz leading-zero blanking; blink_mask per-digit blink;
// bcd/an/digit_idx registered active slot; frame_tick pulse after wrap; bcd_err invalid digit shown.
module bcd_scan_mux #(
  parameter int DIGITS = 4,
  parameter int BANKS = 2,
  parameter int PRESCALE = 50000,
  parameter int BLINK_FRAMES = 64,
  localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1,
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BANKS*DIGITS*4-1:0] digits_in,
  input  logic [BW-1:0]             bank_sel,
  input  logic                      en,
  input  logic                      blank_lz,
  input  logic [DIGITS-1:0]         blink_mask,
  output logic [3:0]                bcd,
  output logic [DIGITS-1:0]         an,
  output logic [IW-1:0]             digit_idx,
  output logic                      frame_tick,
  output logic                      bcd_err
);
  localparam int PW = $clog2(PRESCALE);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PW-1:0] presc;
  logic [BW-1:0] sync0, sync1, active_bank, bank_clamp, bank_nxt;
  logic [FW-1:0] bcnt, bcnt_nxt;
  logic phase, phase_nxt, tick, wrap, last_blink, blank, bad, z;
  logic [IW-1:0] idx_nxt;
  logic [DIGITS*4-1:0] bank_digits;
  logic [DIGITS-1:0] lz, strobe;
  logic [3:0] src;
  // Everything is computed for the index about to be loaded, and for the bank/blink
  // state that will hold after this edge, so a wrap edge already shows the new frame.
  always_comb begin
    tick = en && presc == PW'(PRESCALE-1);
    wrap = tick && digit_idx == IW'(DIGITS-1);
    idx_nxt = digit_idx == IW'(DIGITS-1) ? '0 : digit_idx + 1'b1;
    bank_clamp = int'(sync1) >= BANKS ? BW'(BANKS-1) : sync1;
    bank_nxt = wrap ? bank_clamp : active_bank;
    last_blink = bcnt == FW'(BLINK_FRAMES-1);
    bcnt_nxt = wrap ? (last_blink ? '0 : bcnt + 1'b1) : bcnt;
    phase_nxt = phase ^ (wrap && last_blink);
    bank_digits = digits_in[int'(bank_nxt)*DIGITS*4 +: DIGITS*4];
    z = 1'b1;
    lz = '0;
    // lz[i]: digits DIGITS-1 down to i are all zero
    for (int i = DIGITS-1; i >= 0; i--) begin
      z = z & (bank_digits[i*4 +: 4] == 4'd0);
      lz[i] = z;
    end
    src = bank_digits[int'(idx_nxt)*4 +: 4];
    blank = (blank_lz && idx_nxt != '0 && lz[idx_nxt]) || (phase_nxt && blink_mask[idx_nxt]);
    bad = src > 4'd9;
    strobe = ~(DIGITS'(1) << idx_nxt);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      sync0 <= '0;
      sync1 <= '0;
      active_bank <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      digit_idx <= '0;
      an <= '1;
      bcd <= 4'hF;
      bcd_err <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      sync0 <= bank_sel;
      sync1 <= sync0;
      frame_tick <= wrap;
      if (!en) an <= '1;
      if (en) presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        digit_idx <= idx_nxt;
        active_bank <= bank_nxt;
        bcnt <= bcnt_nxt;
        phase <= phase_nxt;
        an <= blank ? '1 : strobe;
        bcd <= (blank || bad) ? 4'hF : src;
        bcd_err <= !blank && bad;
      end
    end
  end
endmodule

// File: tb/tb_bcd_scan_mux.sv
// tb_bcd_scan_mux: directed table-driven bench for bcd_scan_mux (4 digits, 2 banks, prescale 4, blink 2)
module tb_bcd_scan_mux;
  logic clk, rst_n, en, blank_lz;
  logic [31:0] digits_in;
  logic [0:0] bank_sel;
  logic [3:0] blink_mask, bcd, an;
  logic [1:0] digit_idx;
  logic frame_tick, bcd_err;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] b0, b1;
    logic        sel, blz;
    logic [3:0]  mask;
    logic [11:0] exp;
  } vec_t;
  vec_t vq[$];

  bcd_scan_mux #(.DIGITS(4), .BANKS(2), .PRESCALE(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .bank_sel(bank_sel), .en(en),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .bcd(bcd), .an(an),
    .digit_idx(digit_idx), .frame_tick(frame_tick), .bcd_err(bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected word: {digit_idx, an, bcd, bcd_err, frame_tick}
  task automatic check(input string nm, input logic [11:0] exp);
    logic [11:0] got;
    got = {digit_idx, an, bcd, bcd_err, frame_tick};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got idx=%0d an=%b bcd=%h err=%b ft=%b expected idx=%0d an=%b bcd=%h err=%b ft=%b",
               nm, got[11:10], got[9:6], got[5:2], got[1], got[0],
               exp[11:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // One frame of slots in scan order idx 1,2,3,0; d holds the shown nibble per digit index.
  task automatic add_frame(input logic [15:0] b0, input logic [15:0] b1, input logic sel,
                           input logic blz, input logic [3:0] mask, input logic [15:0] d,
                           input logic [3:0] blk, input logic [3:0] er);
    vec_t v;
    for (int s = 1; s <= 4; s++) begin
      int i;
      logic [3:0] a, b;
      i = s % 4;
      a = blk[i] ? 4'hF : ~(4'b0001 << i);
      b = (blk[i] || er[i]) ? 4'hF : d[i*4 +: 4];
      v.b0 = b0; v.b1 = b1; v.sel = sel; v.blz = blz; v.mask = mask;
      v.exp = {2'(i), a, b, er[i] & ~blk[i], i == 0};
      vq.push_back(v);
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; blank_lz = 1'b0; blink_mask = '0; bank_sel = '0;
    digits_in = {16'h8765, 16'h4321};
    add_frame(16'h4321, 16'h8765, 1'b0, 1'b0, 4'b0000, 16'h4321, 4'b0000, 4'b0000);
    add_frame(16'h4321, 16'h8765, 1'b1, 1'b0, 4'b0000, 16'h4325, 4'b0000, 4'b0000);
    add_frame(16'h4321, 16'h8765, 1'b1, 1'b0, 4'b0000, 16'h8765, 4'b0000, 4'b0000);
    add_frame(16'h0070, 16'h8765, 1'b0, 1'b1, 4'b0000, 16'h8760, 4'b0000, 4'b0000);
    add_frame(16'h0070, 16'h8765, 1'b0, 1'b1, 4'b0000, 16'hFF70, 4'b1100, 4'b0000);
    add_frame(16'h0000, 16'h8765, 1'b0, 1'b1, 4'b0000, 16'hFFF0, 4'b1110, 4'b0000);
    add_frame(16'h43C1, 16'h8765, 1'b0, 1'b0, 4'b0000, 16'h43F1, 4'b0000, 4'b0010);
    add_frame(16'h4321, 16'h8765, 1'b0, 1'b0, 4'b0001, 16'h4321, 4'b0000, 4'b0000);
    add_frame(16'h4321, 16'h8765, 1'b0, 1'b0, 4'b0001, 16'h4321, 4'b0000, 4'b0000);
    add_frame(16'h4321, 16'h8765, 1'b0, 1'b0, 4'b0001, 16'h432F, 4'b0001, 4'b0000);
    add_frame(16'h4321, 16'h8765, 1'b0, 1'b0, 4'b0001, 16'h432F, 4'b0001, 4'b0000);
    add_frame(16'h4321, 16'h8765, 1'b0, 1'b0, 4'b0001, 16'h4321, 4'b0000, 4'b0000);
    #1 rst_n = 1'b0;
    #1 check("reset_async", {2'd0, 4'hF, 4'hF, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("no_strobe_before_tick", {2'd0, 4'hF, 4'hF, 1'b0, 1'b0});
    foreach (vq[k]) begin
      digits_in = {vq[k].b1, vq[k].b0};
      bank_sel = vq[k].sel;
      blank_lz = vq[k].blz;
      blink_mask = vq[k].mask;
      repeat (k == 0 ? 1 : 4) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", k), vq[k].exp);
    end
    digits_in = {16'h8765, 16'h4321};
    blink_mask = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_hold", {2'd1, 4'b1101, 4'h2, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d", c), {2'd1, 4'hF, 4'h2, 1'b0, 1'b0});
    end
    digits_in = {16'h8765, 16'h4C21};
    en = 1'b1;
    @(negedge clk);
    check("resume_wait", {2'd1, 4'hF, 4'h2, 1'b0, 1'b0});
    @(negedge clk);
    check("resume_err", {2'd2, 4'b1011, 4'hF, 1'b1, 1'b0});
    en = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_midframe", {2'd0, 4'hF, 4'hF, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    digits_in = {16'h8765, 16'h4321};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("restart_wait%0d", c), {2'd0, 4'hF, 4'hF, 1'b0, 1'b0});
    end
    @(negedge clk);
    check("restart_first", {2'd1, 4'b1101, 4'h2, 1'b0, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
